// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter: the CPU (never stalled) has priority over a level-requesting DMA port.
// Define CFG_SRAM_ARB_PREEMPT_EN to let a CPU strobe abort an in-flight DMA access instead of queueing.
module sram_arbiter #(
  parameter int unsigned ACC_CYC = 2
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic [19:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuMemRd,
  input  logic        iCpuMemWr,
  output logic [7:0]  oCpuData,
  input  logic        iDmaReq,
  input  logic        iDmaWr,
  input  logic [19:0] iDmaAddr,
  input  logic [7:0]  iDmaData,
  output logic        oDmaAck,
  output logic [7:0]  oDmaData,
  output logic [19:0] oSramA,
  output logic [7:0]  oSramDOut,
  input  logic [7:0]  iSramDIn,
  output logic        oSramDir,
  output logic        oSramCe1,
  output logic        oSramCe2,
  output logic        oSramOe,
  output logic        oSramWe,
  output logic        oBusy
);

`ifdef CFG_SRAM_ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  localparam logic [2:0] LAST = 3'(ACC_CYC - 1);

  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC, DMA_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [19:0] cpu_addr_q, cpu_addr_d, dma_addr_q, dma_addr_d, pend_addr_q, pend_addr_d;
  logic [7:0]  cpu_data_q, cpu_data_d, dma_data_q, dma_data_d, pend_data_q, pend_data_d;
  logic        cpu_wr_q, cpu_wr_d, dma_wr_q, dma_wr_d, pend_wr_q, pend_wr_d;
  logic        pend_q, pend_d, resume_q, resume_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;

  logic cpu_stb, acc_last, dma_abort;
  logic do_cpu, do_dma_new, do_dma_res;
  logic in_acc, in_dma, a_wr, we_slot;

  assign cpu_stb   = iCpuMemRd | iCpuMemWr;
  assign acc_last  = (cnt_q == LAST);
  assign dma_abort = PREEMPT && (state_q == DMA_ACC) && cpu_stb;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_data_d  = cpu_data_q;
    cpu_wr_d    = cpu_wr_q;
    dma_addr_d  = dma_addr_q;
    dma_data_d  = dma_data_q;
    dma_wr_d    = dma_wr_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    pend_wr_d   = pend_wr_q;
    resume_d    = resume_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    do_cpu      = 1'b0;
    do_dma_new  = 1'b0;
    do_dma_res  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_stb || pend_q)  do_cpu = 1'b1;
        else if (resume_q)      do_dma_res = 1'b1;
        else if (iDmaReq)       do_dma_new = 1'b1;
      end
      CPU_ACC: begin
        if (acc_last) begin
          cnt_d = 3'd0;
          if (cpu_stb || pend_q)  do_cpu = 1'b1;
          else if (resume_q)      do_dma_res = 1'b1;
          else if (iDmaReq)       do_dma_new = 1'b1;
          else                    state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DMA_ACC: begin
        if (dma_abort) begin
          // aborted attempt is replayed from its first cycle once the CPU is done
          do_cpu   = 1'b1;
          resume_d = 1'b1;
        end else if (acc_last) begin
          state_d = DMA_DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DMA_DONE: begin
        if (cpu_stb || pend_q) do_cpu = 1'b1;
        else                   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_cpu) begin
      state_d = CPU_ACC;
      cnt_d   = 3'd0;
      pend_d  = 1'b0;
      if (cpu_stb) begin
        cpu_addr_d = iCpuAddr;
        cpu_data_d = iCpuData;
        cpu_wr_d   = iCpuMemWr;
      end else begin
        cpu_addr_d = pend_addr_q;
        cpu_data_d = pend_data_q;
        cpu_wr_d   = pend_wr_q;
      end
    end else if (cpu_stb) begin
      // a newer strobe simply overwrites an older pending one
      pend_d      = 1'b1;
      pend_addr_d = iCpuAddr;
      pend_data_d = iCpuData;
      pend_wr_d   = iCpuMemWr;
    end

    if (do_dma_new) begin
      state_d    = DMA_ACC;
      cnt_d      = 3'd0;
      dma_addr_d = iDmaAddr;
      dma_data_d = iDmaData;
      dma_wr_d   = iDmaWr;
    end
    if (do_dma_res) begin
      state_d  = DMA_ACC;
      cnt_d    = 3'd0;
      resume_d = 1'b0;
    end

    if (state_q == CPU_ACC && acc_last && !cpu_wr_q)
      cpu_rdata_d = iSramDIn;
    if (state_q == DMA_ACC && acc_last && !dma_wr_q && !dma_abort)
      dma_rdata_d = iSramDIn;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      cpu_addr_q  <= '0;
      cpu_data_q  <= '0;
      cpu_wr_q    <= 1'b0;
      dma_addr_q  <= '0;
      dma_data_q  <= '0;
      dma_wr_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      pend_wr_q   <= 1'b0;
      resume_q    <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_data_q  <= cpu_data_d;
      cpu_wr_q    <= cpu_wr_d;
      dma_addr_q  <= dma_addr_d;
      dma_data_q  <= dma_data_d;
      dma_wr_q    <= dma_wr_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      pend_wr_q   <= pend_wr_d;
      resume_q    <= resume_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // SRAM pins decode straight from registered state so reset reaches them without a clock
  assign in_dma  = (state_q == DMA_ACC);
  assign in_acc  = (state_q == CPU_ACC) || in_dma;
  assign a_wr    = in_dma ? dma_wr_q : cpu_wr_q;
  assign we_slot = (ACC_CYC == 2) ? (cnt_q == 3'd0) : ((cnt_q != 3'd0) && !acc_last);

  assign oSramA    = in_acc ? (in_dma ? dma_addr_q : cpu_addr_q) : 20'd0;
  assign oSramDOut = (in_acc && a_wr) ? (in_dma ? dma_data_q : cpu_data_q) : 8'd0;
  assign oSramDir  = in_acc && a_wr;
  assign oSramCe1  = !in_acc;
  assign oSramCe2  = in_acc;
  assign oSramOe   = !(in_acc && !a_wr);
  assign oSramWe   = !(in_acc && a_wr && we_slot && !dma_abort);

  assign oBusy    = (state_q != IDLE);
  assign oDmaAck  = (state_q == DMA_DONE);
  assign oDmaData = dma_rdata_q;
  assign oCpuData = cpu_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: cycle table for CPU accesses plus hand sequences for DMA corners.
// Expectations for the preemption case follow CFG_SRAM_ARB_PREEMPT_EN.
module tb_sram_arbiter;

  logic        iClk, iRstN;
  logic [19:0] iCpuAddr, iDmaAddr;
  logic [7:0]  iCpuData, iDmaData;
  logic        iCpuMemRd, iCpuMemWr, iDmaReq, iDmaWr;
  logic [7:0]  iSramDIn;

  logic [7:0]  oCpuData, oDmaData, oSramDOut;
  logic        oDmaAck, oSramDir, oSramCe1, oSramCe2, oSramOe, oSramWe, oBusy;
  logic [19:0] oSramA;

  logic [7:0]  oCpuData3, oDmaData3, oSramDOut3;
  logic        oDmaAck3, oSramDir3, oSramCe13, oSramCe23, oSramOe3, oSramWe3, oBusy3;
  logic [19:0] oSramA3;

  int n_chk = 0;
  int n_fail = 0;

  sram_arbiter #(.ACC_CYC(2)) u_dut (
    .iClk(iClk), .iRstN(iRstN),
    .iCpuAddr(iCpuAddr), .iCpuData(iCpuData), .iCpuMemRd(iCpuMemRd), .iCpuMemWr(iCpuMemWr),
    .oCpuData(oCpuData),
    .iDmaReq(iDmaReq), .iDmaWr(iDmaWr), .iDmaAddr(iDmaAddr), .iDmaData(iDmaData),
    .oDmaAck(oDmaAck), .oDmaData(oDmaData),
    .oSramA(oSramA), .oSramDOut(oSramDOut), .iSramDIn(iSramDIn), .oSramDir(oSramDir),
    .oSramCe1(oSramCe1), .oSramCe2(oSramCe2), .oSramOe(oSramOe), .oSramWe(oSramWe),
    .oBusy(oBusy)
  );

  sram_arbiter #(.ACC_CYC(3)) u_dut3 (
    .iClk(iClk), .iRstN(iRstN),
    .iCpuAddr(iCpuAddr), .iCpuData(iCpuData), .iCpuMemRd(iCpuMemRd), .iCpuMemWr(iCpuMemWr),
    .oCpuData(oCpuData3),
    .iDmaReq(iDmaReq), .iDmaWr(iDmaWr), .iDmaAddr(iDmaAddr), .iDmaData(iDmaData),
    .oDmaAck(oDmaAck3), .oDmaData(oDmaData3),
    .oSramA(oSramA3), .oSramDOut(oSramDOut3), .iSramDIn(8'h77), .oSramDir(oSramDir3),
    .oSramCe1(oSramCe13), .oSramCe2(oSramCe23), .oSramOe(oSramOe3), .oSramWe(oSramWe3),
    .oBusy(oBusy3)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // SRAM model: 256 bytes indexed by the low address byte, preset contents until written
  logic [7:0]   mem [256];
  logic [255:0] wrt;
  always @(posedge iClk or negedge iRstN) begin
    if (!iRstN) wrt <= '0;
    else if (!oSramCe1 && oSramCe2 && !oSramWe) begin
      mem[oSramA[7:0]] <= oSramDOut;
      wrt[oSramA[7:0]] <= 1'b1;
    end
  end

  function automatic logic [7:0] preset(input logic [7:0] idx);
    case (idx)
      8'h00:   return 8'h41;
      8'hDE:   return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  assign iSramDIn = wrt[oSramA[7:0]] ? mem[oSramA[7:0]] : preset(oSramA[7:0]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rst(input string name);
    chk(name, {oSramCe1, oSramCe2, oSramOe, oSramWe, oSramDir, oSramA, oSramDOut,
               oBusy, oCpuData, oDmaAck, oDmaData},
              {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 20'd0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0});
  endtask

  task automatic idle_inputs();
    iCpuMemRd = 1'b0; iCpuMemWr = 1'b0; iCpuAddr = '0; iCpuData = '0;
    iDmaReq = 1'b0; iDmaWr = 1'b0; iDmaAddr = '0; iDmaData = '0;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRstN = 1'b1;
  endtask

  typedef struct {
    logic        rd, wr;
    logic [19:0] addr;
    logic [7:0]  wd;
    logic [33:0] exp;   // {ce1, ce2, oe, we, dir, A, busy, cpudata}
  } vec_t;

  function automatic vec_t mkv(input logic rd, input logic wr, input logic [19:0] addr,
                               input logic [7:0] wd, input logic ce1, input logic oe,
                               input logic we, input logic dir, input logic [19:0] a,
                               input logic busy, input logic [7:0] cd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
    v.exp = {ce1, ~ce1, oe, we, dir, a, busy, cd};
    return v;
  endfunction

`ifdef CFG_SRAM_ARB_PREEMPT_EN
  localparam int PRE_ACK = 7;
  localparam int PRE_CPU = 3;
`else
  localparam int PRE_ACK = 3;
  localparam int PRE_CPU = 4;
`endif

  initial begin
    vec_t vt [12];
    int   ack_cnt, ack_cyc;
    int   pos [3];
    logic [7:0] ack_dat;

    vt[0]  = mkv(0, 1, 20'h12345, 8'h5A, 1, 1, 1, 0, 20'h00000, 0, 8'h00);
    vt[1]  = mkv(0, 0, 20'h00000, 8'h00, 0, 1, 0, 1, 20'h12345, 1, 8'h00);
    vt[2]  = mkv(0, 0, 20'h00000, 8'h00, 0, 1, 1, 1, 20'h12345, 1, 8'h00);
    vt[3]  = mkv(1, 0, 20'h12345, 8'h00, 1, 1, 1, 0, 20'h00000, 0, 8'h00);
    vt[4]  = mkv(0, 0, 20'h00000, 8'h00, 0, 0, 1, 0, 20'h12345, 1, 8'h00);
    vt[5]  = mkv(0, 0, 20'h00000, 8'h00, 0, 0, 1, 0, 20'h12345, 1, 8'h00);
    vt[6]  = mkv(0, 0, 20'h00000, 8'h00, 1, 1, 1, 0, 20'h00000, 0, 8'h5A);
    vt[7]  = mkv(1, 0, 20'hABCDE, 8'h00, 1, 1, 1, 0, 20'h00000, 0, 8'h5A);
    vt[8]  = mkv(0, 0, 20'h00000, 8'h00, 0, 0, 1, 0, 20'hABCDE, 1, 8'h5A);
    vt[9]  = mkv(0, 0, 20'h00000, 8'h00, 0, 0, 1, 0, 20'hABCDE, 1, 8'h5A);
    vt[10] = mkv(0, 0, 20'h00000, 8'h00, 1, 1, 1, 0, 20'h00000, 0, 8'h3C);
    vt[11] = mkv(0, 0, 20'h00000, 8'h00, 1, 1, 1, 0, 20'h00000, 0, 8'h3C);

    idle_inputs();
    iRstN = 1'b0;
    #2;
    chk_rst("reset_state");
    release_rst();

    // CPU write then reads, one table row per clock
    for (int i = 0; i < 12; i++) begin
      iCpuMemRd = vt[i].rd; iCpuMemWr = vt[i].wr;
      iCpuAddr = vt[i].addr; iCpuData = vt[i].wd;
      #1;
      chk($sformatf("cpu_vec%0d", i),
          {oSramCe1, oSramCe2, oSramOe, oSramWe, oSramDir, oSramA, oBusy, oCpuData},
          vt[i].exp);
      @(negedge iClk);
    end
    idle_inputs();

    // single DMA read
    iDmaReq = 1'b1; iDmaWr = 1'b0; iDmaAddr = 20'hB8000;
    ack_cnt = 0; ack_cyc = -1; ack_dat = '0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k == 1) chk("dma_rd_pins", {oSramA, oSramOe, oSramDir}, {20'hB8000, 1'b0, 1'b0});
      if (oDmaAck) begin
        if (ack_cnt == 0) begin ack_cyc = k; ack_dat = oDmaData; end
        ack_cnt++; iDmaReq = 1'b0;
      end
      @(negedge iClk);
    end
    chk("dma_rd_ack_cyc", 64'(ack_cyc), 64'd3);
    chk("dma_rd_ack_cnt", 64'(ack_cnt), 64'd1);
    chk("dma_rd_data", {56'd0, ack_dat}, 64'h41);

    // simultaneous CPU write and DMA read: CPU first, DMA straight after
    iCpuMemWr = 1'b1; iCpuAddr = 20'h00010; iCpuData = 8'h11;
    iDmaReq = 1'b1; iDmaWr = 1'b0; iDmaAddr = 20'hB8000;
    ack_cnt = 0; ack_cyc = -1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k == 1) begin
        chk("tie_cpu_first", {oSramA, oSramDir, oBusy}, {20'h00010, 1'b1, 1'b1});
        iCpuMemWr = 1'b0;
      end
      if (k == 3) chk("tie_dma_next", {oSramA, oSramOe}, {20'hB8000, 1'b0});
      if (oDmaAck) begin
        if (ack_cnt == 0) ack_cyc = k;
        ack_cnt++; iDmaReq = 1'b0;
      end
      @(negedge iClk);
    end
    chk("tie_ack_cyc", 64'(ack_cyc), 64'd5);
    chk("tie_ack_cnt", 64'(ack_cnt), 64'd1);
    idle_inputs();

    // CPU write strobe on the second DMA access cycle
    iDmaReq = 1'b1; iDmaWr = 1'b1; iDmaAddr = 20'hB8001; iDmaData = 8'h99;
    ack_cnt = 0; ack_cyc = -1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k == 2) begin
        iCpuMemWr = 1'b1; iCpuAddr = 20'h00020; iCpuData = 8'h22;
        #1;
        chk("pre_we_high", 64'(oSramWe), 64'd1);
      end
      if (k == 3) iCpuMemWr = 1'b0;
      if (k == PRE_CPU) chk("pre_cpu_acc", {oSramA, oSramDir, oSramDOut}, {20'h00020, 1'b1, 8'h22});
      if (oDmaAck) begin
        if (ack_cnt == 0) ack_cyc = k;
        ack_cnt++; iDmaReq = 1'b0;
      end
      @(negedge iClk);
    end
    chk("pre_ack_cyc", 64'(ack_cyc), 64'(PRE_ACK));
    chk("pre_ack_cnt", 64'(ack_cnt), 64'd1);
    idle_inputs();

    // reset in the middle of a DMA write
    iDmaReq = 1'b1; iDmaWr = 1'b1; iDmaAddr = 20'h00055; iDmaData = 8'h66;
    @(negedge iClk);
    #1;
    chk("rst_mid_live", {oSramWe, oSramA, oSramDOut}, {1'b0, 20'h00055, 8'h66});
    #2;
    iRstN = 1'b0;
    #1;
    chk_rst("rst_mid_async");
    iDmaReq = 1'b0;
    release_rst();
    ack_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (oDmaAck) ack_cnt++;
      @(negedge iClk);
    end
    chk("rst_no_ack", {32'(ack_cnt), 31'd0, oBusy}, 64'd0);

    // ACC_CYC=3 instance: three back-to-back DMA reads on a held request
    iDmaReq = 1'b1; iDmaWr = 1'b0; iDmaAddr = 20'h00003;
    ack_cnt = 0; ack_dat = '0;
    for (int j = 0; j < 3; j++) pos[j] = -1;
    for (int k = 0; k < 25; k++) begin
      #1;
      if (oDmaAck3) begin
        if (ack_cnt < 3) pos[ack_cnt] = k;
        ack_cnt++;
        if (ack_cnt == 3) begin iDmaReq = 1'b0; ack_dat = oDmaData3; end
      end
      @(negedge iClk);
    end
    chk("b2b_ack_cnt", 64'(ack_cnt), 64'd3);
    chk("b2b_ack0", 64'(pos[0]), 64'd4);
    chk("b2b_ack1", 64'(pos[1]), 64'd9);
    chk("b2b_ack2", 64'(pos[2]), 64'd14);
    chk("b2b_data", {56'd0, ack_dat}, 64'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
